// File: rtl/escalonador_round_robin_if.sv
// escalonador_round_robin_if: scheduler control/status bundle between CPU (master) and scheduler (slave).
// SWITCH_STATS_EN adds the switch/idle statistics counters.
interface escalonador_round_robin_if #(parameter int PID_W = 3);
    logic             start;
    logic [PID_W:0]   num_procs;
    logic             instr_ret;
    logic [31:0]      pc_atual;
    logic             io_req;
    logic             io_done;
    logic [PID_W-1:0] io_done_pid;
    logic             fim_proc;
    logic             troca_contexto;
    logic [PID_W-1:0] processo_atual;
    logic [31:0]      pc_restaurar;
    logic             ocioso;
    logic             todos_fim;
    logic [7:0]       quantum_cnt;
`ifdef SWITCH_STATS_EN
    logic [15:0]      trocas_total;
    logic [15:0]      ociosidade_ciclos;
`endif
    modport master (
        output start, num_procs, instr_ret, pc_atual, io_req, io_done, io_done_pid, fim_proc,
        input troca_contexto, processo_atual, pc_restaurar, ocioso, todos_fim, quantum_cnt
`ifdef SWITCH_STATS_EN
        , input trocas_total, ociosidade_ciclos
`endif
    );
    modport slave (
        input start, num_procs, instr_ret, pc_atual, io_req, io_done, io_done_pid, fim_proc,
        output troca_contexto, processo_atual, pc_restaurar, ocioso, todos_fim, quantum_cnt
`ifdef SWITCH_STATS_EN
        , output trocas_total, ociosidade_ciclos
`endif
    );
endinterface

// File: rtl/escalonador_round_robin.sv
// escalonador_round_robin: round-robin process scheduler with quantum, I/O blocking and PC save/restore.
// Defining SWITCH_STATS_EN adds saturating context-switch and idle-cycle counters.
module escalonador_round_robin #(
    parameter int          MAX_PROCS   = 8,
    parameter int          PID_W       = 3,
    parameter int          QUANTUM     = 16,
    parameter logic [31:0] PC_BASE     = 32'd256,
    parameter logic [31:0] PROC_STRIDE = 32'd128
) (
    input logic clock,
    input logic reset,
    escalonador_round_robin_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SAVE, S_SELECT, S_DISPATCH, S_WAIT, S_FINISHED} state_t;
    typedef enum logic [1:0] {FREE, READY, BLOCKED, DONE} slot_t;
    state_t           r_state;
    slot_t            r_slot [MAX_PROCS];
    logic [31:0]      r_pc [MAX_PROCS];
    logic [PID_W-1:0] r_proc;
    logic             r_first;
    logic [31:0]      r_pcr;
    logic [7:0]       r_qcnt;
    logic [PID_W-1:0] w_base, w_next;
    logic             w_found, w_any_ready, w_any_blocked, w_io_ok, w_expiry;
    logic [PID_W:0]   w_n;
    // descending scan so the nearest READY slot after w_base is the last one assigned
    always_comb begin
        w_base = r_first ? PID_W'(MAX_PROCS - 1) : r_proc;
        w_next = w_base;
        w_found = 1'b0;
        w_any_ready = 1'b0;
        w_any_blocked = 1'b0;
        for (int k = MAX_PROCS; k >= 1; k--)
            if (r_slot[PID_W'(int'(w_base) + k)] == READY) begin
                w_next = PID_W'(int'(w_base) + k);
                w_found = 1'b1;
            end
        for (int i = 0; i < MAX_PROCS; i++) begin
            w_any_ready = w_any_ready | (r_slot[i] == READY);
            w_any_blocked = w_any_blocked | (r_slot[i] == BLOCKED);
        end
    end
    assign w_n = (int'(bus.num_procs) > MAX_PROCS) ? (PID_W+1)'(MAX_PROCS) : bus.num_procs;
    assign w_io_ok = bus.io_done && r_slot[bus.io_done_pid] == BLOCKED && r_state != S_IDLE && r_state != S_FINISHED;
    assign w_expiry = bus.instr_ret && r_qcnt == 8'(QUANTUM - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_proc <= '0;
            r_first <= 1'b0;
            r_pcr <= '0;
            r_qcnt <= '0;
            for (int i = 0; i < MAX_PROCS; i++) begin
                r_slot[i] <= FREE;
                r_pc[i] <= '0;
            end
        end else begin
            if (w_io_ok) r_slot[bus.io_done_pid] <= READY;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    for (int i = 0; i < MAX_PROCS; i++) begin
                        r_slot[i] <= (i < int'(w_n)) ? READY : FREE;
                        r_pc[i] <= PC_BASE + 32'(i) * PROC_STRIDE;
                    end
                    r_first <= 1'b1;
                    r_state <= (w_n == '0) ? S_FINISHED : S_SELECT;
                end
                S_RUN: begin
                    if (bus.instr_ret && r_qcnt != 8'hFF) r_qcnt <= r_qcnt + 8'd1;
                    if (bus.fim_proc) r_slot[r_proc] <= DONE;
                    else if (bus.io_req) r_slot[r_proc] <= BLOCKED;
                    if (bus.fim_proc || bus.io_req || w_expiry) r_state <= S_SAVE;
                end
                S_SAVE: begin
                    r_pc[r_proc] <= bus.pc_atual;
                    r_qcnt <= '0;
                    r_state <= S_SELECT;
                end
                S_SELECT: begin
                    r_first <= 1'b0;
                    if (w_found) begin
                        r_proc <= w_next;
                        r_pcr <= r_pc[w_next];
                        r_state <= S_DISPATCH;
                    end else r_state <= w_any_blocked ? S_WAIT : S_FINISHED;
                end
                S_DISPATCH: r_state <= S_RUN;
                // a slot freed while SELECT was deciding shows up as READY here
                S_WAIT: if (w_io_ok || w_any_ready) r_state <= S_SELECT;
                default: ;
            endcase
        end
    end
    assign bus.troca_contexto = r_state == S_DISPATCH && !reset;
    assign bus.processo_atual = r_proc;
    assign bus.pc_restaurar = r_pcr;
    assign bus.ocioso = r_state == S_WAIT;
    assign bus.todos_fim = r_state == S_FINISHED;
    assign bus.quantum_cnt = r_qcnt;
`ifdef SWITCH_STATS_EN
    logic [15:0] r_trocas, r_ocio;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_trocas <= '0;
            r_ocio <= '0;
        end else begin
            if (r_state == S_DISPATCH && r_trocas != 16'hFFFF) r_trocas <= r_trocas + 16'd1;
            if (r_state == S_WAIT && r_ocio != 16'hFFFF) r_ocio <= r_ocio + 16'd1;
        end
    end
    assign bus.trocas_total = r_trocas;
    assign bus.ociosidade_ciclos = r_ocio;
`endif
endmodule
